// File: rtl/fp_cmul_pkg.sv
// fp_cmul_pkg: shared constants and operand types for the pipelined
// small-float complex multiplier (fp_cmul_pipe and fp_mul_exact).
package fp_cmul_pkg;

   localparam int FP_EXP_W = 4;
   localparam int FP_MAN_W = 3;
   localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;
   localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

   // Operand split into fields, with the hidden bit restored in the significand
   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exponent;
      logic [FP_MAN_W:0]   significand;
      logic                is_zero;
   } fp_operand_t;

   // Unpack a default-format word; exponent field 0 is flushed to zero
   function automatic fp_operand_t fp_unpack(input logic [FP_W-1:0] word);
      fp_operand_t op;
      op.sign        = word[FP_W-1];
      op.exponent    = word[FP_W-2 -: FP_EXP_W];
      op.is_zero     = (op.exponent == '0);
      op.significand = op.is_zero ? '0 : {1'b1, word[FP_MAN_W-1:0]};
      return op;
   endfunction

endpackage

// File: rtl/fp_mul_exact.sv
// fp_mul_exact: exact (unrounded) product of two small floats.
// Returns the full 2*(MAN_W+1)-bit significand product, the biased
// exponent sum and the product sign; flushed operands give an exact zero.
module fp_mul_exact
   import fp_cmul_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W,
   parameter int BIAS  = (1 << (EXP_W - 1)) - 1,
   localparam int W    = 1 + EXP_W + MAN_W,
   localparam int XW   = EXP_W + 3,
   localparam int PW   = 2 * (MAN_W + 1)
) (
   input  logic [W-1:0]           a,
   input  logic [W-1:0]           b,
   output logic                   sign,
   output logic signed [XW-1:0]   expo,
   output logic [PW-1:0]          sig,
   output logic                   zero
);

   logic [EXP_W-1:0] ea;
   logic [EXP_W-1:0] eb;
   logic [PW-1:0]    ma;
   logic [PW-1:0]    mb;

   assign ea   = a[W-2 -: EXP_W];
   assign eb   = b[W-2 -: EXP_W];
   assign ma   = {{(MAN_W + 1){1'b0}}, 1'b1, a[MAN_W-1:0]};
   assign mb   = {{(MAN_W + 1){1'b0}}, 1'b1, b[MAN_W-1:0]};
   assign zero = (ea == '0) || (eb == '0);
   assign sign = a[W-1] ^ b[W-1];
   assign sig  = zero ? '0 : ma * mb;
   assign expo = zero ? '0 : $signed(XW'(ea) + XW'(eb) - XW'(BIAS));

endmodule

// File: rtl/fp_cmul_pipe.sv
// fp_cmul_pipe: three-stage valid/ready pipelined complex multiplier.
// S1 exact partial products, S2 align + add/sub, S3 normalise/round/pack.
// Define FP_CMUL_RNE_EN for round-to-nearest-even; otherwise truncation.
module fp_cmul_pipe
   import fp_cmul_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W,
   parameter int BIAS  = (1 << (EXP_W - 1)) - 1,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_c,
   input  logic [W-1:0] in_d,
   input  logic         in_conj,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_real,
   output logic [W-1:0] out_imag,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int XW   = EXP_W + 3;
   localparam int PW   = 2 * (MAN_W + 1);
   localparam int AW   = PW + 3;
   localparam int EMAX = (1 << EXP_W) - 1;

   typedef struct packed {
      logic          sign;
      logic [XW-1:0] expo;
      logic [PW-1:0] sig;
      logic          zero;
   } prod_t;

   typedef struct packed {
      logic          sign;
      logic [XW-1:0] expo;
      logic [AW:0]   mag;
   } sum_t;

   logic [W-1:0]          mul_x [4];
   logic [W-1:0]          mul_y [4];
   logic                  p_sign [4];
   logic signed [XW-1:0]  p_expo [4];
   logic [PW-1:0]         p_sig [4];
   logic                  p_zero [4];
   prod_t                 prod [4];
   prod_t                 re_y;
   prod_t                 im_y;

   prod_t s1_re_x, s1_re_y, s1_im_x, s1_im_y;
   sum_t  s2_re, s2_im;
   logic  v1, v2;
   logic  ready1, ready2, ready3;

   // Product order: 0 = a*c, 1 = b*d, 2 = a*d, 3 = b*c
   assign mul_x[0] = in_a;
   assign mul_y[0] = in_c;
   assign mul_x[1] = in_b;
   assign mul_y[1] = in_d;
   assign mul_x[2] = in_a;
   assign mul_y[2] = in_d;
   assign mul_x[3] = in_b;
   assign mul_y[3] = in_c;

   for (genvar g = 0; g < 4; g++) begin : g_mul
      fp_mul_exact #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) u_mul (
         .a    (mul_x[g]),
         .b    (mul_y[g]),
         .sign (p_sign[g]),
         .expo (p_expo[g]),
         .sig  (p_sig[g]),
         .zero (p_zero[g])
      );
      assign prod[g] = {p_sign[g], p_expo[g], p_sig[g], p_zero[g]};
   end

   // Handshake: a stage may load when it is empty or its content moves on
   assign ready3   = !out_valid || out_ready;
   assign ready2   = !v2 || ready3;
   assign ready1   = !v1 || ready2;
   assign in_ready = ready1;

   // Add/subtract two signed-magnitude products after aligning the smaller one
   function automatic sum_t add_lane(input prod_t x, input prod_t y);
      prod_t         big;
      prod_t         sml;
      logic          swap;
      logic [XW-1:0] diff;
      logic [AW-1:0] ba;
      logic [AW-1:0] sa;
      logic [AW-1:0] sh;
      sum_t          r;
      swap = x.zero || (!y.zero && (($signed(y.expo) > $signed(x.expo)) ||
                                    ((y.expo == x.expo) && (y.sig > x.sig))));
      big  = swap ? y : x;
      sml  = swap ? x : y;
      diff = big.expo - sml.expo;
      ba   = {big.sig, 3'b000};
      sa   = sml.zero ? '0 : {sml.sig, 3'b000};
      sh   = sa >> diff;
`ifdef FP_CMUL_RNE_EN
      sh[0] = sh[0] | (|(sa & ~({AW{1'b1}} << diff)));
`endif
      r.sign = big.sign;
      r.expo = big.expo;
      if (big.zero)
         r.mag = '0;
      else if (big.sign ^ sml.sign)
         r.mag = {1'b0, ba} - {1'b0, sh};
      else
         r.mag = {1'b0, ba} + {1'b0, sh};
      return r;
   endfunction

   // Normalise on the leading one, round or truncate, then flush/saturate
   function automatic logic [W-1:0] pack_lane(input sum_t s);
      int               lz;
      int               en;
      logic [AW:0]      norm;
      logic [MAN_W-1:0] man;
      logic [W-1:0]     r;
`ifdef FP_CMUL_RNE_EN
      logic             rnd;
      logic             stk;
      logic [MAN_W:0]   inc;
`endif
      lz = AW + 1;
      for (int i = 0; i <= AW; i++)
         if (s.mag[i]) lz = AW - i;
      norm = s.mag << lz;
      en   = int'($signed(s.expo)) + 2 - lz;
      man  = norm[AW-1 -: MAN_W];
`ifdef FP_CMUL_RNE_EN
      rnd = norm[AW-MAN_W-1];
      stk = |norm[AW-MAN_W-2:0];
      inc = {1'b0, man} + {{MAN_W{1'b0}}, (rnd & (stk | man[0]))};
      man = inc[MAN_W-1:0];
      if (inc[MAN_W]) en = en + 1;
`endif
      if ((s.mag == '0) || (en < 1))
         r = '0;
      else if (en > EMAX)
         r = {s.sign, {(W - 1){1'b1}}};
      else
         r = {s.sign, en[EXP_W-1:0], man};
      return r;
   endfunction

   // Fold the conjugate selection into the sign of the second term of each lane
   always_comb begin
      re_y      = prod[1];
      re_y.sign = prod[1].sign ^ ~in_conj;
      im_y      = prod[2];
      im_y.sign = prod[2].sign ^ in_conj;
   end

   // Stage 1: register the four exact products
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
      end else if (ready1) begin
         v1      <= in_valid;
         s1_re_x <= prod[0];
         s1_re_y <= re_y;
         s1_im_x <= prod[3];
         s1_im_y <= im_y;
      end
   end

   // Stage 2: aligned add/sub for the real and imaginary lanes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2 <= 1'b0;
      end else if (ready2) begin
         v2    <= v1;
         s2_re <= add_lane(s1_re_x, s1_re_y);
         s2_im <= add_lane(s1_im_x, s1_im_y);
      end
   end

   // Stage 3: normalise and pack into the output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
      end else if (ready3) begin
         out_valid <= v2;
         if (v2) begin
            out_real <= pack_lane(s2_re);
            out_imag <= pack_lane(s2_im);
         end
      end
   end

endmodule

// File: tb/tb_fp_cmul_pipe.sv
// tb_fp_cmul_pipe: directed self-checking bench for fp_cmul_pipe with
// hand-computed results; expects the RNE variant when FP_CMUL_RNE_EN is set.
module tb_fp_cmul_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_a, in_b, in_c, in_d;
   logic       in_conj;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_real, out_imag;
   logic       out_valid;
   logic       out_ready;

   int checks = 0;
   int passes = 0;
   int received = 0;
   int expected_total = 0;
   logic [15:0] expq [$];
   logic [55:0] vecs [8];

`ifdef FP_CMUL_RNE_EN
   localparam logic [7:0] RND = 8'h43;
`else
   localparam logic [7:0] RND = 8'h42;
`endif

   fp_cmul_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
      .in_conj   (in_conj),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Count one comparison and report it if it does not match
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
   endtask

   // Present one vector {a,b,c,d,conj,re,im} and hold it until accepted
   task automatic applyStimulus(input logic [55:0] v, input logic record);
      logic accepted;
      accepted = 1'b0;
      in_a     = v[55:48];
      in_b     = v[47:40];
      in_c     = v[39:32];
      in_d     = v[31:24];
      in_conj  = v[16];
      in_valid = 1'b1;
      for (int n = 0; n < 50 && !accepted; n++) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checkOutput("accept", accepted, 1);
      if (accepted && record) begin
         expq.push_back(v[15:0]);
         expected_total++;
      end
   endtask

   // Wait, with a bound, for every recorded result to come out
   task automatic waitForDrain();
      for (int n = 0; n < 100 && expq.size() > 0; n++) @(posedge clk);
      #1;
      checkOutput("drain", expq.size(), 0);
   endtask

   // Scoreboard: every output transfer must match the oldest outstanding vector
   always @(negedge clk) begin
      logic [15:0] e;
      if (rst_n && out_valid && out_ready) begin
         received++;
         checkOutput("result_expected", (expq.size() > 0), 1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("out_real", out_real, e[15:8]);
            checkOutput("out_imag", out_imag, e[7:0]);
         end
      end
   end

   // Hard stop if something hangs
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      vecs[0] = {8'h38, 8'h38, 8'h38, 8'h38, 8'h01, 8'h40, 8'h00};
      vecs[1] = {8'h77, 8'h00, 8'h77, 8'h00, 8'h00, 8'h7F, 8'h00};
      vecs[2] = {8'h3D, 8'h00, 8'h3D, 8'h00, 8'h00, RND,   8'h00};
      vecs[3] = {8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[4] = {8'h38, 8'hB8, 8'h40, 8'h38, 8'h00, 8'h44, 8'hB8};
      vecs[5] = {8'h38, 8'hB8, 8'h40, 8'h38, 8'h01, 8'h38, 8'hC4};
      vecs[6] = {8'h05, 8'h38, 8'h38, 8'h38, 8'h00, 8'hB8, 8'h38};
      vecs[7] = {8'hF7, 8'h00, 8'h77, 8'h00, 8'h00, 8'hFF, 8'h00};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_c      = '0;
      in_d      = '0;
      in_conj   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_real", out_real, 0);
      checkOutput("rst_out_imag", out_imag, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // (1+j)*(1+j): latency from the accepting edge
      applyStimulus({8'h38, 8'h38, 8'h38, 8'h38, 8'h00, 8'h00, 8'h40}, 1'b1);
      @(negedge clk);
      checkOutput("lat_cycle1", out_valid, 0);
      @(negedge clk);
      checkOutput("lat_cycle2", out_valid, 0);
      @(negedge clk);
      checkOutput("lat_cycle3", out_valid, 1);
      @(posedge clk);
      #1;
      waitForDrain();

      $display("[TB] streaming directed vectors");
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 1'b1);
      waitForDrain();

      $display("[TB] back-pressure with a full pipeline");
      out_ready = 1'b0;
      applyStimulus(vecs[4], 1'b1);
      applyStimulus(vecs[5], 1'b1);
      applyStimulus(vecs[6], 1'b1);
      in_a     = vecs[2][55:48];
      in_b     = vecs[2][47:40];
      in_c     = vecs[2][39:32];
      in_d     = vecs[2][31:24];
      in_conj  = vecs[2][16];
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput("full_in_ready", in_ready, 0);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_hold_a", {out_real, out_imag}, 16'h44B8);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("still_full", in_ready, 0);
      checkOutput("stall_hold_b", {out_real, out_imag}, 16'h44B8);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(vecs[2], 1'b1);
      waitForDrain();

      $display("[TB] reset with results in flight");
      out_ready = 1'b0;
      applyStimulus(vecs[0], 1'b0);
      applyStimulus(vecs[1], 1'b0);
      applyStimulus(vecs[4], 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("flush_out_valid", out_valid, 0);
      checkOutput("flush_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("result_count", received, expected_total);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fp_cmul_pipe.md
FP_CMUL_PIPE -- requirements
Module: fp_cmul_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 4, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 3, meaning mantissa field width; word width W = 1+EXP_W+MAN_W, sign in MSB.
REQ-003 The block SHALL have parameter BIAS, default 2^(EXP_W-1)-1, meaning the exponent bias.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning a synchronous, active-low reset.
REQ-006 The block SHALL have ports in_a, in_b, in_c, in_d, input, W bits each, meaning operands z1=a+jb and z2=c+jd.
REQ-007 The block SHALL have port in_conj, input, 1 bit, meaning compute z1*conj(z2) instead of z1*z2.
REQ-008 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), meaning the input handshake.
REQ-009 The block SHALL have ports out_real and out_imag, output, W bits each, meaning the result.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), meaning the output handshake.

Function
REQ-011 A transfer SHALL occur on any edge where valid and ready are both high; in_ready SHALL NOT depend combinationally on in_valid.
REQ-012 Non-conjugate mode: Re = ac-bd, Im = ad+bc. Conjugate mode: Re = ac+bd, Im = bc-ad.
REQ-013 The pipeline SHALL have 3 registered stages: S1 four exact significand products with exponent sums; S2 alignment and add/sub at 2*(MAN_W+1)+3 bits (guard/round/sticky); S3 normalise, round, pack.
REQ-014 Latency SHALL be 3 cycles from input transfer to out_valid with no stall; throughput SHALL be 1 result/cycle.
REQ-015 Each stage SHALL advance when its successor is empty or advancing; in_ready = !S1_valid || S1_advancing; when all stages are full and out_ready is low, no stage moves and the outputs hold stable.
REQ-016 Results SHALL leave in acceptance order, with none dropped or duplicated under any out_ready pattern.
REQ-017 An operand with exponent field 0 SHALL be treated as zero (flush-to-zero); any product involving it is exactly 0.
REQ-018 An exact-zero sum or an underflow (normalised exponent below 1) SHALL produce +0 (all bits 0).
REQ-019 Overflow (exponent above 2^EXP_W-1) SHALL saturate to {sign, all-ones exponent, all-ones mantissa}.
REQ-020 Normalisation SHALL left-shift by the leading-zero count after a subtraction and right-shift by 1 after an add carry.

Reset
REQ-021 While rst_n is low at an edge, all stage-valid flags, out_valid, out_real and out_imag SHALL become 0 and in_ready SHALL become 1 on the following cycle.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight results; no output transfer occurs for them.

Configuration
REQ-023 With FP_CMUL_RNE_EN defined, S3 SHALL round to nearest, ties to even, and a rounding carry SHALL renormalise and may saturate.
REQ-024 Without FP_CMUL_RNE_EN, S3 SHALL truncate toward zero and guard/round/sticky logic SHALL be omitted.

Structure
REQ-025 Package fp_cmul_pkg SHALL hold the default EXP_W, MAN_W and BIAS constants and the unpacked-operand struct typedef (sign, exponent, significand, is_zero).
REQ-026 The real product SHALL use one sub-module, fp_mul_exact, instantiated 4 times in S1, which outputs an unrounded significand product, exponent and sign.

Verification (defaults; 1.0=0x38)
REQ-027 (1+j1)*(1+j1), a=b=c=d=0x38, conj=0 -> out_real=0x00, out_imag=0x40, out_valid exactly 3 cycles after accept.
REQ-028 The same operands with conj=1 -> out_real=0x40, out_imag=0x00.
REQ-029 a=c=0x77, b=d=0x00 -> out_real=0x7F (saturated), out_imag=0x00.
REQ-030 a=c=0x3D (1.625), b=d=0 -> out_real=0x43 with FP_CMUL_RNE_EN, 0x42 without.
REQ-031 With out_ready low, push 4 back-to-back inputs -> 3 accepted, then in_ready=0; raise out_ready -> all 4 results emerge in order.
REQ-032 Pulse rst_n low with 3 results in flight -> out_valid=0 and in_ready=1 the next cycle, and none of the 3 results ever appears.
